// File: rtl/alu_dec_bcd_conv.sv
// Sign + packed BCD conversion of the ALU fixed-point result.
// Double-dabble, one magnitude bit per clock, one operand in flight.
module alu_dec_bcd_conv #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       dec_in,
  input  logic                  ovf_in,
  input  logic                  udf_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg_out,
  output logic                  err_out
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t          state;
  logic [IN_W-1:0] mag;
  logic [BW-1:0]   bcd;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   bcd_nx;
  logic [CW-1:0]   cnt;
  logic            neg;
  logic            err;

  // Add-3 correction on every digit >= 5, then shift in the next magnitude bit.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    bcd_nx = {adj[BW-2:0], mag[IN_W-1]};
  end

  // Conversion FSM with registered handshake and result outputs.
  // Two's-complement negatives are never zero, so neg needs no zero check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      neg_out   <= 1'b0;
      err_out   <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            neg      <= dec_in[IN_W-1];
            mag      <= dec_in[IN_W-1] ? (~dec_in + 1'b1) : dec_in;
            err      <= ovf_in | udf_in;
            bcd      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd <= bcd_nx;
          mag <= {mag[IN_W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd_out   <= bcd_nx;
            neg_out   <= neg;
            err_out   <= err;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dec_bcd_conv.sv
// Directed bench for alu_dec_bcd_conv.
// Hand-computed BCD results, latency, hold and reset behaviour.
module tb_alu_dec_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dec_in;
  logic        ovf_in;
  logic        udf_in;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] bcd_out;
  logic        neg_out;
  logic        err_out;

  int total = 0;
  int bad   = 0;

  alu_dec_bcd_conv #(.IN_W(32), .DIGITS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dec_in    (dec_in),
    .ovf_in    (ovf_in),
    .udf_in    (udf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .neg_out   (neg_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] d, input logic o,
                          input logic u);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_rdy", {63'd0, in_ready}, 64'd1);
    dec_in   = d;
    ovf_in   = o;
    udf_in   = u;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("take_valid", {63'd0, out_valid}, 64'd0);
    check("take_rdy", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] d,
                       input logic o, input logic u,
                       input logic [39:0] eb, input logic en,
                       input logic ee);
    int n;
    start_op(d, o, u);
    check({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
    wait_done(n);
    check({tag, "_lat"}, 64'(n), 64'd32);
    check({tag, "_bcd"}, {24'd0, bcd_out}, {24'd0, eb});
    check({tag, "_neg"}, {63'd0, neg_out}, {63'd0, en});
    check({tag, "_err"}, {63'd0, err_out}, {63'd0, ee});
    take();
  endtask

  initial begin
    int   n;
    logic seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    dec_in    = '0;
    ovf_in    = 1'b0;
    udf_in    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_rdy", {63'd0, in_ready}, 64'd1);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_bcd", {24'd0, bcd_out}, 64'd0);
    check("rst_neg", {63'd0, neg_out}, 64'd0);
    check("rst_err", {63'd0, err_out}, 64'd0);
    rst = 1'b0;
    tick();

    do_op("p300", 32'd300, 1'b0, 1'b0, 40'h0000000300, 1'b0, 1'b0);
    do_op("m2000", 32'hFFFF_F830, 1'b0, 1'b0, 40'h0000002000, 1'b1, 1'b0);
    do_op("m100", 32'hFFFF_FF9C, 1'b0, 1'b0, 40'h0000000100, 1'b1, 1'b0);
    do_op("mneg", 32'h8000_0000, 1'b0, 1'b0, 40'h2147483648, 1'b1, 1'b0);
    do_op("zero", 32'd0, 1'b0, 1'b0, 40'h0000000000, 1'b0, 1'b0);
    do_op("mpos", 32'h7FFF_FFFF, 1'b0, 1'b0, 40'h2147483647, 1'b0, 1'b0);
    do_op("m1", 32'hFFFF_FFFF, 1'b0, 1'b0, 40'h0000000001, 1'b1, 1'b0);
    do_op("ovf", 32'd30, 1'b1, 1'b0, 40'h0000000030, 1'b0, 1'b1);
    do_op("udf", 32'd12345, 1'b0, 1'b1, 40'h0000012345, 1'b0, 1'b1);
    do_op("clr", 32'd999, 1'b0, 1'b0, 40'h0000000999, 1'b0, 1'b0);

    // busy input ignored, result held while consumer stalls
    start_op(32'hFFFF_F830, 1'b0, 1'b1);
    dec_in   = 32'd777;
    ovf_in   = 1'b0;
    udf_in   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("conv_rdy", {63'd0, in_ready}, 64'd0);
    end
    wait_done(n);
    check("hold_lat", 64'(n), 64'd29);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_bcd", {24'd0, bcd_out}, 64'h2000);
      check("hold_neg", {63'd0, neg_out}, 64'd1);
      check("hold_err", {63'd0, err_out}, 64'd1);
      check("done_rdy", {63'd0, in_ready}, 64'd0);
      tick();
    end
    in_valid = 1'b0;
    take();
    check("kept_bcd", {24'd0, bcd_out}, 64'h2000);

    // reset on the 10th conversion clock discards the operand
    start_op(32'd4321, 1'b1, 1'b0);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_bcd", {24'd0, bcd_out}, 64'd0);
    check("mrst_neg", {63'd0, neg_out}, 64'd0);
    check("mrst_err", {63'd0, err_out}, 64'd0);
    check("mrst_rdy", {63'd0, in_ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mrst_nopulse", {63'd0, seen}, 64'd0);
    do_op("after", 32'd30, 1'b0, 1'b0, 40'h0000000030, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
